// File: rtl/alu_dsp48_wide_seq.sv
// Splits one wide ADD/SUB/AND/OR request into W-bit limbs for AluDsp48, chaining carry/borrow serially
// (3 cycles per arithmetic limb, logic limbs pipelined); result is held in DONE until resp_ready.
module alu_dsp48_wide_seq #(
   parameter int W     = 16,
   parameter int LIMBS = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [2:0]           req_limbs,
   input  logic [W*LIMBS-1:0]   req_a,
   input  logic [W*LIMBS-1:0]   req_b,
   input  logic                 req_cin,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [W*LIMBS-1:0]   resp_data,
   output logic                 resp_cout,
   output logic [W-1:0]         dsp_in0,
   output logic [W-1:0]         dsp_in1,
   output logic                 dsp_carryin,
   output logic [8:0]           dsp_opmode,
   output logic [3:0]           dsp_alumode,
   output logic [1:0]           dsp_setinst,
   output logic                 dsp_valid_in,
   input  logic [W-1:0]         dsp_out,
   input  logic                 dsp_carryout,
   input  logic                 dsp_valid_out
);

   localparam int CW = $clog2(LIMBS + 1);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE, ARITH_ISSUE, ARITH_WAIT, LOGIC_STREAM, LOGIC_DRAIN, DONE
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         op_q, issue_op;
   logic [CW-1:0]      n_q, eff_limbs, iss_cnt, rcv_cnt, issue_idx;
   logic [W*LIMBS-1:0] a_q, b_q;
   logic               accept, issue, issue_cin, capture, last_limb, chain;
   logic [W-1:0]       sel_a, sel_b;

   assign req_ready   = (state == IDLE) && !reset;
   assign resp_valid  = (state == DONE);
   assign dsp_setinst = 2'b00;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      issue     = 1'b0;
      issue_idx = '0;
      issue_cin = 1'b0;
      capture   = 1'b0;
      last_limb = 1'b0;
      // DSP48E2 subtract reports borrow as an active-low carryout
      chain     = (op_q == OP_SUB) ? ~dsp_carryout : dsp_carryout;

      if (req_limbs == 3'd0)          eff_limbs = CW'(1);
      else if (int'(req_limbs) > LIMBS) eff_limbs = CW'(LIMBS);
      else                            eff_limbs = CW'(req_limbs);

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept    = 1'b1;
               issue     = 1'b1;
               issue_cin = req_op[1] ? 1'b0 : req_cin;
               state_nxt = req_op[1] ? LOGIC_STREAM : ARITH_ISSUE;
            end
         end
         ARITH_ISSUE: state_nxt = ARITH_WAIT;
         ARITH_WAIT: begin
            if (dsp_valid_out) begin
               capture = 1'b1;
               if (rcv_cnt == n_q - CW'(1)) begin
                  last_limb = 1'b1;
                  state_nxt = DONE;
               end else begin
                  issue     = 1'b1;
                  issue_idx = rcv_cnt + CW'(1);
                  issue_cin = chain;
                  state_nxt = ARITH_ISSUE;
               end
            end
         end
         LOGIC_STREAM, LOGIC_DRAIN: begin
            if (state == LOGIC_STREAM) begin
               if (iss_cnt < n_q) begin
                  issue     = 1'b1;
                  issue_idx = iss_cnt;
               end else begin
                  state_nxt = LOGIC_DRAIN;
               end
            end
            if (dsp_valid_out) begin
               capture = 1'b1;
               if (rcv_cnt == n_q - CW'(1)) begin
                  last_limb = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < LIMBS; k++) begin
         if (CW'(k) == issue_idx) begin
            sel_a = a_q[k*W +: W];
            sel_b = b_q[k*W +: W];
         end
      end
      // Limb 0 goes out on the acceptance edge, before the operands are latched
      if (accept) begin
         sel_a = req_a[W-1:0];
         sel_b = req_b[W-1:0];
      end
      issue_op = accept ? req_op : op_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dsp_in0      <= '0;
         dsp_in1      <= '0;
         dsp_carryin  <= 1'b0;
         dsp_opmode   <= '0;
         dsp_alumode  <= '0;
         dsp_valid_in <= 1'b0;
         resp_data    <= '0;
         resp_cout    <= 1'b0;
         op_q         <= OP_ADD;
         n_q          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         iss_cnt      <= '0;
         rcv_cnt      <= '0;
      end else begin
         dsp_valid_in <= issue;
         if (issue) begin
            dsp_in0     <= sel_a;
            dsp_in1     <= sel_b;
            dsp_carryin <= issue_cin;
            dsp_opmode  <= (issue_op == OP_OR) ? 9'b000111011 : 9'b000110011;
            case (issue_op)
               OP_ADD:  dsp_alumode <= 4'b0000;
               OP_SUB:  dsp_alumode <= 4'b0011;
               default: dsp_alumode <= 4'b1100;
            endcase
         end
         if (accept) begin
            op_q      <= req_op;
            n_q       <= eff_limbs;
            a_q       <= req_a;
            b_q       <= req_b;
            resp_data <= '0;
            resp_cout <= 1'b0;
            iss_cnt   <= CW'(1);
            rcv_cnt   <= '0;
         end else if (issue) begin
            iss_cnt <= iss_cnt + CW'(1);
         end
         if (capture) begin
            for (int k = 0; k < LIMBS; k++) begin
               if (CW'(k) == rcv_cnt) resp_data[k*W +: W] <= dsp_out;
            end
            rcv_cnt <= rcv_cnt + CW'(1);
            if (last_limb) resp_cout <= op_q[1] ? 1'b0 : chain;
         end
      end
   end

endmodule

// File: tb/tb_alu_dsp48_wide_seq.sv
// Directed bench for alu_dsp48_wide_seq with a 2-cycle AluDsp48 stand-in and a wide-arithmetic reference model.
module tb_alu_dsp48_wide_seq;
   localparam int W = 16;
   localparam int LIMBS = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_ready;
   logic [1:0]    req_op = '0;
   logic [2:0]    req_limbs = '0;
   logic [63:0]   req_a = '0, req_b = '0;
   logic          req_cin = 1'b0;
   logic          resp_valid, resp_ready = 1'b0;
   logic [63:0]   resp_data;
   logic          resp_cout;
   logic [W-1:0]  dsp_in0, dsp_in1;
   logic          dsp_carryin;
   logic [8:0]    dsp_opmode;
   logic [3:0]    dsp_alumode;
   logic [1:0]    dsp_setinst;
   logic          dsp_valid_in;
   logic [W-1:0]  dsp_out = '0;
   logic          dsp_carryout = 1'b0, dsp_valid_out = 1'b0;

   int total = 0;
   int bad = 0;

   alu_dsp48_wide_seq #(.W(W), .LIMBS(LIMBS)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_limbs(req_limbs),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_cout(resp_cout),
      .dsp_in0(dsp_in0), .dsp_in1(dsp_in1), .dsp_carryin(dsp_carryin),
      .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode), .dsp_setinst(dsp_setinst),
      .dsp_valid_in(dsp_valid_in), .dsp_out(dsp_out), .dsp_carryout(dsp_carryout),
      .dsp_valid_out(dsp_valid_out)
   );

   always #5 clock = ~clock;

   // AluDsp48 stand-in: 2-cycle latency, active-low borrow on subtract, not reset
   function automatic logic [W:0] dsp_fn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                         input logic [8:0] opm, input logic [3:0] alu);
      logic [W:0] t;
      t = '0;
      case (alu)
         4'b0000: t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
         4'b0011: begin
            t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
            t[W] = ~t[W];
         end
         4'b1100: t = {1'b0, opm[3] ? (x | y) : (x & y)};
         default: t = '0;
      endcase
      return t;
   endfunction

   logic [W-1:0] p1_d = '0;
   logic         p1_c = 1'b0, p1_v = 1'b0;
   always @(posedge clock) begin
      {p1_c, p1_d}  <= dsp_fn(dsp_in0, dsp_in1, dsp_carryin, dsp_opmode, dsp_alumode);
      p1_v          <= dsp_valid_in;
      dsp_out       <= p1_d;
      dsp_carryout  <= p1_c;
      dsp_valid_out <= p1_v;
   end

   // Reference: {cout, data} of an n-limb operation done as one wide integer op
   function automatic logic [64:0] model(input logic [1:0] op, input int n, input logic [63:0] a,
                                         input logic [63:0] b, input logic cin);
      logic [64:0] m, s, aa, bb;
      logic        c;
      m  = (65'd1 << (16 * n)) - 65'd1;
      aa = {1'b0, a} & m;
      bb = {1'b0, b} & m;
      c  = 1'b0;
      case (op)
         2'b00: begin s = aa + bb + {64'd0, cin}; c = s[16*n]; end
         2'b01: begin s = aa - bb - {64'd0, cin}; c = (aa < bb + {64'd0, cin}); end
         2'b10: s = aa & bb;
         default: s = aa | bb;
      endcase
      s = s & m;
      return {c, s[63:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   bit          mon_on = 1'b0;
   int          mon_cyc = 0;
   logic [1:0]  m_op;
   int          m_n, m_rise;
   logic [63:0] m_a, m_b;
   logic        m_cin;
   logic [64:0] m_exp;

   // Per-cycle check of DSP issue traffic and the response against the model
   always @(negedge clock) begin
      if (mon_on) begin
         bit exp_vin;
         int k;
         logic [64:0] pre;
         mon_cyc++;
         if (m_op[1]) exp_vin = (mon_cyc >= 1) && (mon_cyc <= m_n);
         else         exp_vin = ((mon_cyc - 1) % 3 == 0) && ((mon_cyc - 1) / 3 < m_n);
         chk("dsp_valid_in", {63'd0, dsp_valid_in}, {63'd0, exp_vin});
         chk("dsp_setinst", {62'd0, dsp_setinst}, 64'd0);
         if (exp_vin) begin
            k   = m_op[1] ? mon_cyc - 1 : (mon_cyc - 1) / 3;
            pre = model(m_op, k, m_a, m_b, m_cin);
            chk("dsp_in0", {48'd0, dsp_in0}, {48'd0, m_a[16*k +: 16]});
            chk("dsp_in1", {48'd0, dsp_in1}, {48'd0, m_b[16*k +: 16]});
            chk("dsp_carryin", {63'd0, dsp_carryin}, {63'd0, m_op[1] ? 1'b0 : pre[64]});
            chk("dsp_opmode", {55'd0, dsp_opmode}, {55'd0, (m_op == 2'b11) ? 9'b000111011 : 9'b000110011});
            chk("dsp_alumode", {60'd0, dsp_alumode},
                {60'd0, m_op[1] ? 4'b1100 : (m_op[0] ? 4'b0011 : 4'b0000)});
         end
         chk("resp_valid", {63'd0, resp_valid}, {63'd0, mon_cyc >= m_rise});
         if (resp_valid) begin
            chk("resp_data", resp_data, m_exp[63:0]);
            chk("resp_cout", {63'd0, resp_cout}, {63'd0, m_exp[64]});
            chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
         end
      end
   end

   task automatic wait_ready();
      int w;
      @(negedge clock);
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic run(input logic [1:0] op, input logic [2:0] lim, input logic [63:0] a,
                      input logic [63:0] b, input logic cin, input int hold,
                      input logic [63:0] lit_d, input logic lit_c, input int lit_rise);
      int n, w;
      n      = (lim == 0) ? 1 : ((lim > 4) ? 4 : int'(lim));
      m_op   = op; m_n = n; m_a = a; m_b = b; m_cin = cin; m_rise = lit_rise;
      m_exp  = model(op, n, a, b, cin);
      wait_ready();
      req_valid = 1'b1; req_op = op; req_limbs = lim; req_a = a; req_b = b; req_cin = cin;
      @(posedge clock);
      mon_cyc = 0;
      mon_on  = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      w = 1;
      while (!resp_valid && w < 60) begin
         @(negedge clock);
         w++;
      end
      chk("resp_arrived", {63'd0, resp_valid}, 64'd1);
      chk("lit_rise_cycle", 64'(w), 64'(lit_rise));
      chk("lit_data", resp_data, lit_d);
      chk("lit_cout", {63'd0, resp_cout}, {63'd0, lit_c});
      repeat (hold) @(negedge clock);
      resp_ready = 1'b1;
      @(posedge clock);
      mon_on = 1'b0;
      @(negedge clock);
      resp_ready = 1'b0;
      chk("req_ready_after_resp", {63'd0, req_ready}, 64'd1);
      chk("resp_valid_after_resp", {63'd0, resp_valid}, 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("req_ready_in_reset", {63'd0, req_ready}, 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_dsp_valid_in", {63'd0, dsp_valid_in}, 64'd0);

      run(2'b00, 3'd2, 64'h0000_FFFF, 64'h1, 1'b0, 0, 64'h10000, 1'b0, 7);
      run(2'b01, 3'd4, 64'h0, 64'h1, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 13);
      run(2'b10, 3'd3, 64'h0000_F0F0_FF00_1234, 64'hFFFF_0FF0_0F0F_FFFF, 1'b0, 0,
          64'h0000_00F0_0F00_1234, 1'b0, 6);
      run(2'b00, 3'd0, 64'hFFFF, 64'h0, 1'b1, 0, 64'h0, 1'b1, 4);
      run(2'b11, 3'd1, 64'h00F0, 64'h0F00, 1'b0, 5, 64'h0FF0, 1'b0, 4);
      run(2'b00, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 64'h0, 1'b1, 13);
      run(2'b01, 3'd2, 64'h0001_0000, 64'h0000_0001, 1'b1, 0, 64'h0000_FFFE, 1'b0, 7);

      // Reset mid-way through a 4-limb ADD, then recover
      wait_ready();
      req_valid = 1'b1; req_op = 2'b00; req_limbs = 3'd4;
      req_a = 64'hFFFF_FFFF; req_b = 64'h1; req_cin = 1'b0;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("mid_limb1_issue", {63'd0, dsp_valid_in}, 64'd1);
      chk("mid_limb1_carry", {63'd0, dsp_carryin}, 64'd1);
      reset = 1'b1;
      #1;
      chk("req_ready_in_reset2", {63'd0, req_ready}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst2_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst2_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst2_resp_data", resp_data, 64'd0);
      chk("rst2_resp_cout", {63'd0, resp_cout}, 64'd0);
      chk("rst2_dsp_bus", {dsp_in0, dsp_in1, 32'd0}, 64'd0);
      chk("rst2_dsp_ctl", {49'd0, dsp_carryin, dsp_opmode, dsp_alumode, dsp_valid_in}, 64'd0);
      repeat (3) begin
         @(negedge clock);
         chk("stale_ignored_vld", {63'd0, resp_valid}, 64'd0);
         chk("stale_ignored_issue", {63'd0, dsp_valid_in}, 64'd0);
      end
      run(2'b00, 3'd1, 64'h7FFF, 64'h0001, 1'b0, 0, 64'h8000, 1'b0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_dsp48_wide_seq.md
# alu_dsp48_wide_seq

Multi-limb operation sequencer that sits directly upstream of `AluDsp48`. It accepts one request for an operation of up to `LIMBS`×`W` bits and splits it into `W`-bit limbs. It drives `AluDsp48` with the matching opmode/alumode controls and chains carry/borrow between limbs across the DSP's 2-cycle latency. It then returns the assembled wide result with a final carry flag.

## Interface
Parameters:
- `W`, 16: limb width; equals `AluDsp48` datapath width.
- `LIMBS`, 4: maximum limbs per request.

Ports (clock/reset: one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer accepts a request; high only in IDLE.
- `req_op`  in  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- `req_limbs`  in  3  limb count; 0 treated as 1; >LIMBS clamped to LIMBS.
- `req_a`, `req_b`  in  W*LIMBS  operands; limb k = bits [W*k+W-1 : W*k].
- `req_cin`  in  1  ADD: carry-in; SUB: borrow-in; ignored for logic ops.
- `resp_valid`  out  1  result available; held until `resp_ready`.
- `resp_ready`  in  1  consumer takes result.
- `resp_data`  out  W*LIMBS  result; limbs ≥ effective count are 0.
- `resp_cout`  out  1  ADD: final carry; SUB: final borrow (1 = A < B + cin unsigned); logic: 0.
- `dsp_in0`, `dsp_in1`  out  W  limb of A, limb of B.
- `dsp_carryin`  out  1  chained carry/borrow.
- `dsp_opmode`  out  9; `dsp_alumode`  out  4; `dsp_setinst`  out  2 (always 00).
- `dsp_valid_in`  out  1  limb issued this cycle.
- `dsp_out`  in  W; `dsp_carryout`  in  1; `dsp_valid_out`  in  1  from `AluDsp48`.

## Operation
- Controls per op (opmode/alumode): ADD 000110011/0000; SUB 000110011/0011 (DSP computes in0 − in1 − carryin); AND 000110011/1100; OR 000111011/1100.
- All `dsp_*` outputs are registered.
- FSM states: IDLE → (req handshake) → ARITH_ISSUE ⇄ ARITH_WAIT, or LOGIC_STREAM → LOGIC_DRAIN; both paths end in DONE → (resp handshake) → IDLE.
- Operands, op and effective limb count are latched at acceptance. The result register is cleared at acceptance.
- ADD/SUB:
  - Issue one limb, then wait for `dsp_valid_out`.
  - Capture `dsp_out` into limb slot k.
  - Carry into limb k+1: ADD uses `dsp_carryout`; SUB uses `~dsp_carryout` (DSP48E2 subtract carryout is active-low borrow).
  - Limb 0 uses `req_cin`.
  - After the last limb, `resp_cout` is the chained value computed from that limb's carryout.
- AND/OR:
  - Issue limbs on consecutive cycles with `dsp_carryin` = 0.
  - A result index counter writes each `dsp_valid_out` into the next slot in order.
  - Go to DONE when the count of received results equals the limb count.
- `dsp_valid_out` is ignored in IDLE and DONE, so stale in-flight results after a reset are discarded.
- Reset in any state: next cycle state = IDLE.
  - `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_cout`=0.
  - All `dsp_*` outputs = 0.
  - Counters cleared.
- While `reset` is high, `req_ready`=0.

## Timing
- Acceptance edge ends cycle 0.
- ADD/SUB, n limbs:
  - Limb k is issued in cycle 1+3k, and its result arrives in cycle 3+3k.
  - `resp_valid` rises in cycle 3n+1.
  - `dsp_valid_in` is a single-cycle pulse per limb.
- AND/OR, n limbs:
  - `dsp_valid_in` is high in cycles 1..n.
  - Results arrive in cycles 3..n+2.
  - `resp_valid` rises in cycle n+3.
- `resp_data`/`resp_cout` are stable while `resp_valid` is high.
- Response handshake in cycle t → IDLE in t+1 (`req_ready`=1). The earliest next acceptance is in t+1.
- No request is accepted in the same cycle as a response handshake.

## Test plan
All cases use W=16, LIMBS=4, driving a real `AluDsp48`.
- ADD, 2 limbs, A=0x0000FFFF, B=0x00000001, cin=0 → `resp_data`=0x10000, `resp_cout`=0, `resp_valid` rises in cycle 7; `dsp_carryin`=1 on the limb-1 issue.
- SUB, 4 limbs, A=0, B=1, cin=0 → `resp_data`=0xFFFF_FFFF_FFFF_FFFF, `resp_cout`=1, `resp_valid` in cycle 13.
- AND, 3 limbs, A=0x0000_F0F0_FF00_1234, B=0xFFFF_0FF0_0F0F_FFFF → `dsp_valid_in` high in cycles 1–3; `resp_data`=0x0000_00F0_0F00_1234 in cycle 6.
- ADD, `req_limbs`=0, A=0xFFFF, B=0, cin=1 → treated as 1 limb; `resp_data`=0x0000, `resp_cout`=1.
- Backpressure: OR, 1 limb, 0x00F0|0x0F00, with `resp_ready`=0 for 5 cycles → `resp_data`=0x0FF0 held stable and `req_ready`=0 throughout; after the handshake, `req_ready`=1 next cycle.
- Reset asserted in cycle 4 of a 4-limb ADD → the following cycle is IDLE with all outputs at reset values; the stale `dsp_valid_out` is ignored. A new ADD of 0x7FFF + 0x0001 (1 limb) → 0x8000, `resp_cout`=0.
